// File: rtl/issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_scoreboard: DECODE-to-execute issue control with a pending-write    |
// | scoreboard, outstanding-write limit and MUL busy sequencing.              |
// | Optional stall counter: define ISSUE_SCOREBOARD_STALL_CNT_EN.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module issue_scoreboard #(
  parameter int          NUM_REGS     = 32,
  parameter int          MAX_INFLIGHT = 4,
  parameter int          MUL_LAT      = 3,
  parameter logic [3:0]  MUL_CODE     = 4'b0110
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [3:0]          id_ctrl,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_uses_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_regwrite,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic                ex_issue,
  output logic [3:0]          ex_ctrl,
  output logic [4:0]          ex_rd,
  output logic [NUM_REGS-1:0] pending_mask,
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic [3:0]          inflight_cnt,
  output logic                mul_busy
);

  localparam int         c_cnt_w        = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_mul_lat = c_cnt_w'(MUL_LAT);
  localparam logic [3:0] c_max_inflight = 4'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_mul_cnt, w_mul_cnt_nxt;
  logic [NUM_REGS-1:0]  r_pending, w_pending_nxt, w_eff_pending;
  logic [3:0]           r_inflight, w_inflight_nxt;
  logic                 r_ex_issue;
  logic [3:0]           r_ex_ctrl;
  logic [4:0]           r_ex_rd;
  logic                 w_hazard, w_wb_hit, w_full, w_ready, w_issue, w_set;

  // Writeback in the current cycle is bypassed so a dependent op can issue alongside it.
  always_comb begin
    w_eff_pending = r_pending;
    if (wb_valid) w_eff_pending[wb_rd] = 1'b0;
    w_eff_pending[0] = 1'b0;
  end

  assign w_hazard = w_eff_pending[id_rs1]
                  | (id_uses_rs2 & w_eff_pending[id_rs2])
                  | (id_regwrite & w_eff_pending[id_rd]);
  assign w_wb_hit = wb_valid & r_pending[wb_rd] & (wb_rd != 5'd0);
  assign w_full   = id_regwrite & (r_inflight == c_max_inflight) & ~w_wb_hit;
  assign w_ready  = reset & (r_state == ST_RUN) & ~w_hazard & ~w_full & ~flush;
  assign w_issue  = id_valid & w_ready;
  assign w_set    = w_issue & id_regwrite & (id_rd != 5'd0);

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_hit) w_pending_nxt[wb_rd] = 1'b0;
    if (w_set)    w_pending_nxt[id_rd] = 1'b1;
    w_inflight_nxt = r_inflight;
    case ({w_set, w_wb_hit})
      2'b10:   w_inflight_nxt = r_inflight + 4'd1;
      2'b01:   w_inflight_nxt = r_inflight - 4'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_issue && (id_ctrl == MUL_CODE)) begin
          w_state_nxt   = ST_MUL_BUSY;
          w_mul_cnt_nxt = c_mul_lat;
        end
      end
      ST_MUL_BUSY: begin
        if (r_mul_cnt <= c_cnt_w'(1)) begin
          w_state_nxt   = ST_RUN;
          w_mul_cnt_nxt = '0;
        end else begin
          w_mul_cnt_nxt = r_mul_cnt - c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_mul_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_mul_cnt  <= '0;
      r_pending  <= '0;
      r_inflight <= '0;
      r_ex_issue <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
    end else if (flush) begin
      r_state    <= ST_RUN;
      r_mul_cnt  <= '0;
      r_pending  <= '0;
      r_inflight <= '0;
      r_ex_issue <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mul_cnt  <= w_mul_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
      r_ex_issue <= w_issue;
      if (w_issue) begin
        r_ex_ctrl <= id_ctrl;
        r_ex_rd   <= id_rd;
      end
    end
  end

`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (id_valid && !w_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign id_ready     = w_ready;
  assign ex_issue     = r_ex_issue;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_rd        = r_ex_rd;
  assign pending_mask = r_pending;
  assign inflight_cnt = r_inflight;
  assign mul_busy     = (r_state == ST_MUL_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_issue_scoreboard: directed self-checking bench for issue_scoreboard.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_ctrl;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        ex_issue;
  logic [3:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic [31:0] pending_mask;
  logic [3:0]  inflight_cnt;
  logic        mul_busy;
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  issue_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_ctrl      (id_ctrl),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .ex_issue     (ex_issue),
    .ex_ctrl      (ex_ctrl),
    .ex_rd        (ex_rd),
    .pending_mask (pending_mask),
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .inflight_cnt (inflight_cnt),
    .mul_busy     (mul_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d,
                       input logic rw);
    id_valid = v; id_ctrl = c; id_rs1 = s1; id_rs2 = s2;
    id_uses_rs2 = u2; id_rd = d; id_regwrite = rw;
  endtask

  task automatic wb(input logic v, input logic [4:0] d);
    wb_valid = v; wb_rd = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    wb(0, 0);

    // Reset
    step(); step();
    chk("rst_pending", pending_mask, 32'h0);
    chk("rst_inflight", inflight_cnt, 0);
    chk("rst_ex_issue", ex_issue, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_mul_busy", mul_busy, 0);
    chk("rst_id_ready_low", id_ready, 0);
    reset = 1'b1;
    step();
    chk("rel_id_ready", id_ready, 1);
    chk("rel_ex_issue", ex_issue, 0);

    // RAW stall released by same-cycle writeback
    drive(1, 4'b0010, 0, 0, 0, 5, 1);
    #1 chk("add_ready", id_ready, 1);
    step();
    chk("add_ex_issue", ex_issue, 1);
    chk("add_ex_rd", ex_rd, 5);
    chk("add_ex_ctrl", ex_ctrl, 4'b0010);
    chk("add_pending", pending_mask, 32'h20);
    chk("add_inflight", inflight_cnt, 1);
    drive(1, 4'b0010, 5, 0, 0, 6, 1);
    #1 chk("raw_stall", id_ready, 0);
    step();
    chk("raw_no_issue", ex_issue, 0);
    chk("raw_ex_rd_hold", ex_rd, 5);
    step();
    chk("raw_still_stall", id_ready, 0);
    wb(1, 5);
    #1 chk("raw_bypass_ready", id_ready, 1);
    step();
    chk("raw_issue", ex_issue, 1);
    chk("raw_issue_rd", ex_rd, 6);
    chk("raw_pending", pending_mask, 32'h40);
    chk("raw_inflight", inflight_cnt, 1);

    // rs2 and WAW hazards against x6
    wb(0, 0);
    drive(1, 4'b0010, 0, 6, 1, 7, 1);
    #1 chk("rs2_stall", id_ready, 0);
    drive(1, 4'b0010, 0, 6, 0, 7, 1);
    #1 chk("rs2_unused_ready", id_ready, 1);
    drive(0, 4'b0010, 0, 0, 0, 6, 1);
    #1 chk("waw_stall", id_ready, 0);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    wb(1, 6);
    step();
    chk("clr6_pending", pending_mask, 32'h0);
    chk("clr6_inflight", inflight_cnt, 0);

    // Same-register wb and issue: set wins, count net 0
    wb(0, 0);
    drive(1, 4'b0010, 0, 0, 0, 5, 1);
    step();
    chk("sw5_pending", pending_mask, 32'h20);
    drive(1, 4'b0010, 5, 0, 0, 5, 1);
    wb(1, 5);
    #1 chk("sw5_ready", id_ready, 1);
    step();
    chk("sw5_issue", ex_issue, 1);
    chk("sw5_pending_set", pending_mask, 32'h20);
    chk("sw5_inflight", inflight_cnt, 1);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    step();
    chk("sw5_clear", pending_mask, 32'h0);
    chk("sw5_inflight0", inflight_cnt, 0);
    wb(0, 0);

    // MUL busy for exactly MUL_LAT cycles
    drive(1, 4'b0110, 0, 0, 0, 8, 1);
    step();
    chk("mul_issue", ex_issue, 1);
    chk("mul_ctrl", ex_ctrl, 4'b0110);
    chk("mul_busy_c1", mul_busy, 1);
    chk("mul_pending", pending_mask, 32'h100);
    drive(1, 4'b0001, 0, 0, 0, 9, 1);
    #1 chk("mul_ready_c1", id_ready, 0);
    step();
    chk("mul_no_issue_c2", ex_issue, 0);
    chk("mul_busy_c2", mul_busy, 1);
    chk("mul_ready_c2", id_ready, 0);
    step();
    chk("mul_busy_c3", mul_busy, 1);
    chk("mul_ready_c3", id_ready, 0);
    step();
    chk("mul_busy_c4", mul_busy, 0);
    chk("mul_ready_c4", id_ready, 1);
    step();
    chk("or_issue", ex_issue, 1);
    chk("or_ctrl", ex_ctrl, 4'b0001);
    chk("or_rd", ex_rd, 9);
    chk("or_pending", pending_mask, 32'h300);
    chk("or_inflight", inflight_cnt, 2);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    wb(1, 8);
    step();
    wb(1, 9);
    step();
    chk("mul_clr_pending", pending_mask, 32'h0);
    chk("mul_clr_inflight", inflight_cnt, 0);
    wb(0, 0);

    // Outstanding-write limit
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'b0010, 0, 0, 0, 5'(i), 1);
      step();
    end
    chk("full_inflight", inflight_cnt, 4);
    chk("full_pending", pending_mask, 32'h1E);
    drive(1, 4'b0010, 0, 0, 0, 5, 1);
    #1 chk("full_stall", id_ready, 0);
    drive(1, 4'b0010, 0, 0, 0, 5, 0);
    #1 chk("full_store_ready", id_ready, 1);
    step();
    chk("full_store_issue", ex_issue, 1);
    chk("full_store_inflight", inflight_cnt, 4);
    chk("full_store_pending", pending_mask, 32'h1E);
    drive(1, 4'b0010, 0, 0, 0, 5, 1);
    wb(1, 2);
    #1 chk("full_wb_ready", id_ready, 1);
    step();
    chk("full_wb_inflight", inflight_cnt, 4);
    chk("full_wb_pending", pending_mask, 32'h3A);
    drive(1, 4'b0010, 0, 0, 0, 2, 1);
    wb(1, 5);
    step();
    chk("full_swap_inflight", inflight_cnt, 4);
    chk("full_swap_pending", pending_mask, 32'h1E);
    wb(0, 0);

    // Flush during MUL with pending writes
    drive(1, 4'b0110, 0, 0, 0, 0, 0);
    step();
    chk("fl_mul_busy", mul_busy, 1);
    chk("fl_pre_pending", pending_mask, 32'h1E);
    drive(1, 4'b0010, 0, 0, 0, 10, 1);
    flush = 1'b1;
    #1 chk("fl_ready", id_ready, 0);
    step();
    chk("fl_pending", pending_mask, 32'h0);
    chk("fl_inflight", inflight_cnt, 0);
    chk("fl_mul_busy_clr", mul_busy, 0);
    chk("fl_ex_issue", ex_issue, 0);
    flush = 1'b0;
    #1 chk("fl_after_ready", id_ready, 1);
    drive(0, 4'h0, 0, 0, 0, 0, 0);

    // x0 destination and writeback to a non-pending register
    drive(1, 4'b0010, 0, 0, 0, 0, 1);
    wb(1, 7);
    step();
    chk("x0_issue", ex_issue, 1);
    chk("x0_ex_rd", ex_rd, 0);
    chk("x0_pending", pending_mask, 32'h0);
    chk("x0_inflight", inflight_cnt, 0);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    wb(0, 0);

    // Reset in the middle of a MUL
    drive(1, 4'b0110, 0, 0, 0, 3, 1);
    step();
    chk("rm_mul_busy", mul_busy, 1);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("rm_mul_busy_clr", mul_busy, 0);
    chk("rm_pending", pending_mask, 32'h0);
    chk("rm_inflight", inflight_cnt, 0);
    chk("rm_ex_issue", ex_issue, 0);
    chk("rm_ex_ctrl", ex_ctrl, 0);
    chk("rm_ready", id_ready, 0);
    reset = 1'b1;
    #1 chk("rm_rel_ready", id_ready, 1);
    step();
    chk("rm_rel_ex_issue", ex_issue, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between the DECODE stage and the execute datapath.
- Keeps a per-register pending-write scoreboard and stalls decoded instructions on RAW or WAW hazards against in-flight writers.
- Limits the number of outstanding register writes.
- Sequences the multi-cycle MUL unit: no new issue while a MUL is busy.
- Issued operations go to execute through a registered valid/control/rd slot.

Parameters:
- NUM_REGS, 32: number of architectural registers (x0 hard-wired zero).
- MAX_INFLIGHT, 4: maximum outstanding register writes (1..15).
- MUL_LAT, 3: cycles the MUL unit is busy after issue (>=1).
- MUL_CODE, 4'b0110: control code that selects MUL.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  controller accepts the instruction this cycle.
- id_ctrl  in  4  ALU control code from decode.
- id_rs1  in  5  source register 1.
- id_rs2  in  5  source register 2.
- id_uses_rs2  in  1  rs2 is a real operand.
- id_rd  in  5  destination register.
- id_regwrite  in  1  instruction writes rd.
- wb_valid  in  1  writeback completes this cycle.
- wb_rd  in  5  register written back.
- flush  in  1  discard all in-flight tracking.
- ex_issue  out  1  one-cycle pulse: operation issued to execute.
- ex_ctrl  out  4  registered control of the issued operation.
- ex_rd  out  5  registered destination of the issued operation.
- pending_mask  out  NUM_REGS  scoreboard bits, bit r = write pending to xr.
- inflight_cnt  out  4  outstanding-write count.
- mul_busy  out  1  MUL unit occupied.

Behaviour:
- Reset (reset=0 at clock edge):
  - pending_mask=0, inflight_cnt=0, ex_issue=0, ex_ctrl=0, ex_rd=0, mul_busy=0, FSM=RUN.
  - id_ready=0 while reset is low.
- FSM states: RUN and MUL_BUSY.
  - RUN -> MUL_BUSY on a handshake with id_ctrl==MUL_CODE; the busy counter loads MUL_LAT.
  - MUL_BUSY: the counter decrements each cycle. When it reaches 1, the next state is RUN.
  - Net effect: exactly MUL_LAT cycles after the issue edge have id_ready=0.
- Hazard (combinational, uses current-cycle writeback bypass):
  - eff_pending = pending_mask with bit wb_rd cleared when wb_valid=1.
  - hazard = eff_pending[id_rs1] | (id_uses_rs2 & eff_pending[id_rs2]) | (id_regwrite & eff_pending[id_rd]).
  - Register 0 never counts as pending.
- Full: full = id_regwrite & (inflight_cnt==MAX_INFLIGHT) & !(wb_valid & pending_mask[wb_rd]).
- id_ready = reset & state==RUN & !hazard & !full & !flush.
- Handshake: issue = id_valid & id_ready.
  - Next edge: ex_issue=1, ex_ctrl=id_ctrl, ex_rd=id_rd.
  - With no handshake, ex_issue=0 and ex_ctrl/ex_rd hold their values.
  - Issue latency is 1 cycle; sustained throughput is 1 per cycle when there is no hazard.
  - id_valid may drop without a handshake; nothing is latched in that case.
- Scoreboard update at each edge, in priority order:
  - flush: pending_mask=0, inflight_cnt=0, FSM=RUN, ex_issue=0. Flush overrides a simultaneous wb or issue.
  - wb_valid with pending[wb_rd]=1: clear the bit; decrement inflight.
  - wb_valid on a non-pending register or x0: ignored, no count change.
  - Issue with id_regwrite and id_rd!=0: set pending[id_rd]; increment inflight.
  - Issue with id_rd==0 or id_regwrite=0: no scoreboard or count change.
  - Same-edge wb and issue: the count changes by net 0. If both target the same register, set wins. Under the WAW rule this only happens via the bypass.
- inflight_cnt never exceeds MAX_INFLIGHT and never underflows.
- Reset mid-MUL or mid-stall returns to the reset state with no residual issue.

Optional Feature:
- Macro: ISSUE_SCOREBOARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles, 32 bits.
  - Increments each cycle with id_valid=1 and id_ready=0; saturates at 2^32-1.
  - Cleared by reset only; not cleared by flush.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0; id_ready=1 the cycle after release.
- Issue ADD rd=5 (ctrl 0010), next cycle rs1=5 with no wb:
  - ex_issue pulses once with ex_rd=5; pending_mask=0x20.
  - Dependent instruction is stalled until wb_valid with wb_rd=5. It issues in the same cycle as that wb (bypass); pending bit 5 is then set again only if the dependent instruction itself has rd=5.
- Issue MUL (0110) with MUL_LAT=3:
  - mul_busy=1 and id_ready=0 for exactly 3 cycles.
  - A following OR issues on cycle 4.
- Four regwrite issues to rd=1..4, no wb:
  - inflight_cnt=4; the 5th regwrite is stalled.
  - A SW-like instruction (id_regwrite=0) still issues.
  - wb_rd=2 in the same cycle lets the 5th issue; count stays 4.
- Flush asserted while pending_mask=0x1E and MUL_BUSY:
  - Next cycle pending_mask=0, inflight_cnt=0, mul_busy=0, ex_issue=0.
  - A simultaneous id_valid is not accepted.
- id_rd=0 with regwrite, and wb_rd=7 for a non-pending register -> no pending bit set, inflight unchanged.
